// File: rtl/frame_max_finder.sv
// Frame maximum finder: per FRAME_LEN-sample frame, reports the max, the index of its first occurrence and
// the number of running-max replacements. Define FRAME_MIN_EN to add out_min / out_min_idx.
module frame_max_finder #(
   parameter int WIDTH     = 8,
   parameter int FRAME_LEN = 8,
   localparam int IDXW     = $clog2(FRAME_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [IDXW-1:0]  out_idx,
   output logic [IDXW-1:0]  out_upd
`ifdef FRAME_MIN_EN
   ,
   output logic [WIDTH-1:0] out_min,
   output logic [IDXW-1:0]  out_min_idx
`endif
);

   // Handshakes: a sample moves when in_valid && in_ready, a result moves when out_valid && out_ready;
   // in_ready comes from the state register alone, so it never combinationally follows in_valid.
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

   state_t           state_q;
   logic [IDXW-1:0]  cnt_q;
   logic [WIDTH-1:0] max_q;
   logic [IDXW-1:0]  idx_q;
   logic [IDXW-1:0]  upd_q;
   logic             valid_q;
   logic             beat;
   logic             new_max;
   logic [IDXW-1:0]  cnt_d;
   logic [IDXW-1:0]  upd_d;
`ifdef FRAME_MIN_EN
   logic [WIDTH-1:0] min_q;
   logic [IDXW-1:0]  min_idx_q;
   logic             new_min;
`endif

   assign in_ready  = (state_q != HOLD);
   assign beat      = in_valid && in_ready;
   assign new_max   = (in_data > max_q);
   assign cnt_d     = cnt_q + IDXW'(1);
   assign upd_d     = upd_q + IDXW'(1);
`ifdef FRAME_MIN_EN
   assign new_min   = (in_data < min_q);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         max_q     <= '0;
         idx_q     <= '0;
         upd_q     <= '0;
         valid_q   <= 1'b0;
`ifdef FRAME_MIN_EN
         min_q     <= '0;
         min_idx_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (beat) begin
                  max_q   <= in_data;
                  idx_q   <= '0;
                  upd_q   <= '0;
                  cnt_q   <= IDXW'(1);
                  state_q <= ACCUM;
`ifdef FRAME_MIN_EN
                  min_q     <= in_data;
                  min_idx_q <= '0;
`endif
               end
            end
            ACCUM: begin
               if (beat) begin
                  // Strict compares: ties keep the earlier index and do not count as a replacement.
                  if (new_max) begin
                     max_q <= in_data;
                     idx_q <= cnt_q;
                     upd_q <= upd_d;
                  end
`ifdef FRAME_MIN_EN
                  if (new_min) begin
                     min_q     <= in_data;
                     min_idx_q <= cnt_q;
                  end
`endif
                  if (cnt_q == LAST_IDX) begin
                     cnt_q   <= '0;
                     valid_q <= 1'b1;
                     state_q <= HOLD;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = valid_q;
   assign out_max   = max_q;
   assign out_idx   = idx_q;
   assign out_upd   = upd_q;
`ifdef FRAME_MIN_EN
   assign out_min     = min_q;
   assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_frame_max_finder.sv
// Bench for frame_max_finder (WIDTH=2, FRAME_LEN=4): directed vector table, reset sequences and random
// frames scored against a reference model. Min outputs are checked when FRAME_MIN_EN is defined.
module tb_frame_max_finder;

   localparam int W  = 2;
   localparam int FL = 4;
   localparam int IW = 2;
   localparam int RW = 2 * W + 3 * IW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_max;
   logic [IW-1:0] out_idx;
   logic [IW-1:0] out_upd;
`ifdef FRAME_MIN_EN
   logic [W-1:0]  out_min;
   logic [IW-1:0] out_min_idx;
`endif

   int errors = 0;
   int checks = 0;

   // Expected results, packed as {max, idx, upd, min, min_idx}.
   logic [RW-1:0] exp_q[$];

   typedef struct {
      logic [FL-1:0][W-1:0] s;
      bit                   gappy;
      int                   hold;
      int                   e_max;
      int                   e_idx;
      int                   e_upd;
      int                   e_min;
      int                   e_min_idx;
   } vec_t;

   vec_t vecs[$];

   frame_max_finder #(.WIDTH(W), .FRAME_LEN(FL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_idx   (out_idx),
      .out_upd   (out_upd)
`ifdef FRAME_MIN_EN
      ,
      .out_min     (out_min),
      .out_min_idx (out_min_idx)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] pack(input int mx, input int ix, input int up, input int mn, input int mni);
      return {W'(mx), IW'(ix), IW'(up), W'(mn), IW'(mni)};
   endfunction

   // Reference: max/min of the whole frame, first position holding them, and how many samples beat
   // every sample before them.
   function automatic logic [RW-1:0] model(input logic [FL-1:0][W-1:0] s);
      int mx = 0, mn = (1 << W) - 1, ix = -1, mni = -1, up = 0;
      bit rec;
      for (int i = 0; i < FL; i++) begin
         if (int'(s[i]) > mx) mx = s[i];
         if (int'(s[i]) < mn) mn = s[i];
      end
      for (int i = 0; i < FL; i++) begin
         if (ix < 0 && int'(s[i]) == mx) ix = i;
         if (mni < 0 && int'(s[i]) == mn) mni = i;
      end
      for (int i = 1; i < FL; i++) begin
         rec = 1'b1;
         for (int j = 0; j < i; j++) if (s[j] >= s[i]) rec = 1'b0;
         if (rec) up++;
      end
      return pack(mx, ix, up, mn, mni);
   endfunction

   task automatic add_vec(input int a, input int b, input int c, input int d, input bit g, input int h,
                          input int mx, input int ix, input int up, input int mn, input int mni);
      vec_t v;
      v.s[0] = W'(a); v.s[1] = W'(b); v.s[2] = W'(c); v.s[3] = W'(d);
      v.gappy = g; v.hold = h;
      v.e_max = mx; v.e_idx = ix; v.e_upd = up; v.e_min = mn; v.e_min_idx = mni;
      vecs.push_back(v);
   endtask

   task automatic drive_samples(input logic [FL-1:0][W-1:0] s, input bit gappy, input bit ready_during);
      int i = 0;
      int cyc = 0;
      bit tog = 1'b1;
      out_ready = ready_during;
      while (i < FL && cyc < 64) begin
         @(negedge clk);
         in_valid = gappy ? tog : 1'b1;
         tog = ~tog;
         in_data = in_valid ? s[i] : W'($urandom);
         if (in_valid && in_ready) i++;
         cyc++;
      end
      if (i < FL) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: got %0d beats expected %0d", i, FL);
      end
   endtask

   // Check the result the cycle after the last beat, hold it for 'hold' extra cycles, then accept it.
   task automatic collect(input int hold);
      logic [RW-1:0] e;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = W'($urandom);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check("latency_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("max", out_max, e[3*IW+W +: W]);
      check("idx", out_idx, e[2*IW+W +: IW]);
      check("upd", out_upd, e[IW+W +: IW]);
`ifdef FRAME_MIN_EN
      check("min", out_min, e[IW +: W]);
      check("min_idx", out_min_idx, e[0 +: IW]);
`endif
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_max", out_max, e[3*IW+W +: W]);
         check("bp_idx", out_idx, e[2*IW+W +: IW]);
         check("bp_upd", out_upd, e[IW+W +: IW]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("drain_valid", out_valid, 0);
      check("drain_in_ready", in_ready, 1);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_max"}, out_max, 0);
      check({tag, "_idx"}, out_idx, 0);
      check({tag, "_upd"}, out_upd, 0);
`ifdef FRAME_MIN_EN
      check({tag, "_min"}, out_min, 0);
      check({tag, "_min_idx"}, out_min_idx, 0);
`endif
   endtask

   initial begin
      logic [FL-1:0][W-1:0] s;
      bit g;
      int h;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_cleared("reset");

      //          samples     gap hold  max idx upd min midx
      add_vec(1, 3, 2, 3, 0, 0,   3, 1, 1,  1, 0);
      add_vec(0, 1, 2, 3, 0, 0,   3, 3, 3,  0, 0);
      add_vec(3, 2, 1, 0, 0, 0,   3, 0, 0,  0, 3);
      add_vec(2, 2, 2, 2, 1, 0,   2, 0, 0,  2, 0);
      add_vec(0, 2, 1, 3, 0, 5,   3, 3, 2,  0, 0);
      add_vec(1, 3, 0, 0, 0, 0,   3, 1, 1,  0, 2);
      add_vec(3, 3, 3, 3, 1, 2,   3, 0, 0,  3, 0);
      add_vec(1, 0, 2, 1, 0, 1,   2, 2, 1,  0, 1);

      foreach (vecs[k]) begin
         exp_q.push_back(pack(vecs[k].e_max, vecs[k].e_idx, vecs[k].e_upd, vecs[k].e_min, vecs[k].e_min_idx));
         drive_samples(vecs[k].s, vecs[k].gappy, vecs[k].hold == 0);
         collect(vecs[k].hold);
      end

      // Reset after two samples of a frame: the partial frame must leave no trace.
      @(negedge clk); in_valid = 1'b1; in_data = 2'd3;
      @(negedge clk); in_valid = 1'b1; in_data = 2'd3;
      @(negedge clk); in_valid = 1'b0; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_cleared("midrst");
      s = {2'd0, 2'd0, 2'd1, 2'd0};
      exp_q.push_back(pack(1, 1, 1, 0, 0));
      drive_samples(s, 1'b0, 1'b1);
      collect(0);

      // Reset while a result is pending in HOLD: the result is dropped.
      s = {2'd0, 2'd1, 2'd2, 2'd3};
      drive_samples(s, 1'b0, 1'b0);
      @(negedge clk); in_valid = 1'b0;
      check("pend_valid", out_valid, 1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_cleared("holdrst");
      s = {2'd2, 2'd1, 2'd2, 2'd1};
      exp_q.push_back(pack(2, 1, 1, 1, 0));
      drive_samples(s, 1'b0, 1'b1);
      collect(0);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < FL; i++) s[i] = W'($urandom_range(0, (1 << W) - 1));
         g = 1'($urandom_range(0, 1));
         h = $urandom_range(0, 3);
         exp_q.push_back(model(s));
         drive_samples(s, g, h == 0);
         collect(h);
      end

      check("scoreboard_left", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
